// File: rtl/multicycle_main_controller.sv
// ============================================================================
// Module   : multicycle_main_controller
// Brief    : Main control FSM for the multi-cycle RISC-V datapath.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_main_controller #(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [6:0]         op,
   input  logic               mem_ready,
   output logic               mem_read,
   output logic               mem_write,
   output logic               adr_src,
   output logic               ir_write,
   output logic               pc_write,
   output logic               reg_write,
   output logic [1:0]         alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [1:0]         alu_op,
   output logic [2:0]         imm_src,
   output logic [1:0]         result_src,
   output logic               branch,
   output logic               illegal,
   output logic [STATE_W-1:0] state
);

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADR   = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXEC_R    = 4'd6,
      S_EXEC_I    = 4'd7,
      S_ALU_WB    = 4'd8,
      S_BRANCH    = 4'd9,
      S_JAL       = 4'd10,
      S_JALR_ADR  = 4'd11,
      S_LUI       = 4'd12
   } state_t;

   localparam logic [6:0] c_OP_R    = 7'b0110011;
   localparam logic [6:0] c_OP_I    = 7'b0010011;
   localparam logic [6:0] c_OP_LW   = 7'b0000011;
   localparam logic [6:0] c_OP_SW   = 7'b0100011;
   localparam logic [6:0] c_OP_BR   = 7'b1100011;
   localparam logic [6:0] c_OP_JAL  = 7'b1101111;
   localparam logic [6:0] c_OP_JALR = 7'b1100111;
   localparam logic [6:0] c_OP_LUI  = 7'b0110111;

   localparam logic [1:0] c_A_PC    = 2'b00;
   localparam logic [1:0] c_A_OLDPC = 2'b01;
   localparam logic [1:0] c_A_RS1   = 2'b10;
   localparam logic [1:0] c_B_RS2   = 2'b00;
   localparam logic [1:0] c_B_IMM   = 2'b01;
   localparam logic [1:0] c_B_FOUR  = 2'b10;
   localparam logic [2:0] c_IMM_I   = 3'b000;
   localparam logic [2:0] c_IMM_S   = 3'b001;
   localparam logic [2:0] c_IMM_B   = 3'b010;
   localparam logic [2:0] c_IMM_J   = 3'b011;
   localparam logic [2:0] c_IMM_U   = 3'b100;

   state_t     r_state;
   state_t     w_next;
   logic       r_illegal;
   logic       w_set_illegal;
   logic [3:0] w_state_bits;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_FETCH;
         r_illegal <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_set_illegal) begin
            r_illegal <= 1'b1;
         end
      end
   end

   always_comb begin
      w_next        = r_state;
      w_set_illegal = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      adr_src       = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = c_A_PC;
      alu_src_b     = c_B_RS2;
      alu_op        = 2'b00;
      imm_src       = c_IMM_I;
      result_src    = 2'b00;
      branch        = 1'b0;

      case (r_state)
         S_FETCH: begin
            mem_read   = 1'b1;
            alu_src_a  = c_A_PC;
            alu_src_b  = c_B_FOUR;
            result_src = 2'b10;
            ir_write   = mem_ready;
            pc_write   = mem_ready;
            if (mem_ready) begin
               w_next = S_DECODE;
            end
         end
         S_DECODE: begin
            // ALUOut captures OldPC + imm as the branch/JAL target.
            alu_src_a = c_A_OLDPC;
            alu_src_b = c_B_IMM;
            case (op)
               c_OP_BR:  imm_src = c_IMM_B;
               c_OP_JAL: imm_src = c_IMM_J;
               default:  imm_src = c_IMM_I;
            endcase
            case (op)
               c_OP_R:          w_next = S_EXEC_R;
               c_OP_I:          w_next = S_EXEC_I;
               c_OP_LW, c_OP_SW: w_next = S_MEM_ADR;
               c_OP_BR:         w_next = S_BRANCH;
               c_OP_JAL:        w_next = S_JAL;
               c_OP_JALR:       w_next = S_JALR_ADR;
               c_OP_LUI:        w_next = S_LUI;
               default: begin
                  w_next        = S_FETCH;
                  w_set_illegal = 1'b1;
               end
            endcase
         end
         S_MEM_ADR: begin
            alu_src_a = c_A_RS1;
            alu_src_b = c_B_IMM;
            imm_src   = op[5] ? c_IMM_S : c_IMM_I;
            w_next    = op[5] ? S_MEM_WRITE : S_MEM_READ;
         end
         S_MEM_READ: begin
            mem_read = 1'b1;
            adr_src  = 1'b1;
            if (mem_ready) begin
               w_next = S_MEM_WB;
            end
         end
         S_MEM_WB: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
            w_next     = S_FETCH;
         end
         S_MEM_WRITE: begin
            mem_write = 1'b1;
            adr_src   = 1'b1;
            if (mem_ready) begin
               w_next = S_FETCH;
            end
         end
         S_EXEC_R: begin
            alu_src_a = c_A_RS1;
            alu_src_b = c_B_RS2;
            alu_op    = 2'b10;
            w_next    = S_ALU_WB;
         end
         S_EXEC_I: begin
            alu_src_a = c_A_RS1;
            alu_src_b = c_B_IMM;
            imm_src   = c_IMM_I;
            alu_op    = 2'b10;
            w_next    = S_ALU_WB;
         end
         S_ALU_WB: begin
            result_src = 2'b00;
            reg_write  = 1'b1;
            w_next     = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a  = c_A_RS1;
            alu_src_b  = c_B_RS2;
            alu_op     = 2'b01;
            branch     = 1'b1;
            result_src = 2'b00;
            w_next     = S_FETCH;
         end
         S_JAL: begin
            // PC takes the target from ALUOut while the ALU forms OldPC + 4.
            alu_src_a  = c_A_OLDPC;
            alu_src_b  = c_B_FOUR;
            result_src = 2'b00;
            pc_write   = 1'b1;
            w_next     = S_ALU_WB;
         end
         S_JALR_ADR: begin
            alu_src_a = c_A_RS1;
            alu_src_b = c_B_IMM;
            imm_src   = c_IMM_I;
            w_next    = S_JAL;
         end
         S_LUI: begin
            imm_src    = c_IMM_U;
            result_src = 2'b11;
            reg_write  = 1'b1;
            w_next     = S_FETCH;
         end
         default: begin
            w_next = S_FETCH;
         end
      endcase

      // State already sits in FETCH during reset; only the strobes need masking.
      if (!rst) begin
         mem_read  = 1'b0;
         mem_write = 1'b0;
         ir_write  = 1'b0;
         pc_write  = 1'b0;
         reg_write = 1'b0;
         branch    = 1'b0;
      end
   end

   assign illegal      = r_illegal;
   assign w_state_bits = r_state;

   generate
      if (STATE_W > 4) begin : g_state_pad
         assign state = {{(STATE_W-4){1'b0}}, w_state_bits};
      end else begin : g_state_direct
         assign state = w_state_bits[STATE_W-1:0];
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_multicycle_main_controller.sv
// ============================================================================
// Module   : tb_multicycle_main_controller
// Brief    : Directed scoreboard bench for the multi-cycle main controller.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multicycle_main_controller;

   logic       clk;
   logic       rst;
   logic [6:0] op;
   logic       mem_ready;
   logic       mem_read, mem_write, adr_src, ir_write, pc_write, reg_write;
   logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
   logic [2:0] imm_src;
   logic       branch, illegal;
   logic [3:0] state;

   int passes = 0;
   int total  = 0;

   typedef struct {
      string       tag;
      logic [3:0]  st;
      logic [17:0] ctrl;
      logic        ill;
   } exp_t;

   exp_t sb[$];

   multicycle_main_controller #(.STATE_W(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .op         (op),
      .mem_ready  (mem_ready),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .adr_src    (adr_src),
      .ir_write   (ir_write),
      .pc_write   (pc_write),
      .reg_write  (reg_write),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_op     (alu_op),
      .imm_src    (imm_src),
      .result_src (result_src),
      .branch     (branch),
      .illegal    (illegal),
      .state      (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference control table:
   // {mem_read, mem_write, adr_src, ir_write, pc_write, reg_write,
   //  alu_src_a, alu_src_b, alu_op, imm_src, result_src, branch}
   function automatic logic [17:0] ref_ctrl(input logic [3:0] st, input logic [6:0] o,
                                            input logic rdy, input logic rstn);
      logic mr, mw, adr, irw, pcw, rw, br;
      logic [1:0] a, b, aop, res;
      logic [2:0] imm;
      mr = 0; mw = 0; adr = 0; irw = 0; pcw = 0; rw = 0; br = 0;
      a = 2'b00; b = 2'b00; aop = 2'b00; res = 2'b00; imm = 3'b000;
      case (st)
         4'd0:  begin mr = rstn; irw = rdy & rstn; pcw = rdy & rstn; b = 2'b10; res = 2'b10; end
         4'd1:  begin a = 2'b01; b = 2'b01;
                      imm = (o == 7'b1100011) ? 3'b010 : (o == 7'b1101111) ? 3'b011 : 3'b000; end
         4'd2:  begin a = 2'b10; b = 2'b01; imm = o[5] ? 3'b001 : 3'b000; end
         4'd3:  begin mr = 1; adr = 1; end
         4'd4:  begin res = 2'b01; rw = 1; end
         4'd5:  begin mw = 1; adr = 1; end
         4'd6:  begin a = 2'b10; b = 2'b00; aop = 2'b10; end
         4'd7:  begin a = 2'b10; b = 2'b01; aop = 2'b10; end
         4'd8:  begin rw = 1; end
         4'd9:  begin a = 2'b10; b = 2'b00; aop = 2'b01; br = 1; end
         4'd10: begin a = 2'b01; b = 2'b10; pcw = 1; end
         4'd11: begin a = 2'b10; b = 2'b01; end
         4'd12: begin imm = 3'b100; res = 2'b11; rw = 1; end
         default: ;
      endcase
      return {mr, mw, adr, irw, pcw, rw, a, b, aop, imm, res, br};
   endfunction

   task automatic step(input string tag, input logic rstn, input logic [6:0] o,
                       input logic rdy, input logic [3:0] exp_st, input logic exp_ill);
      exp_t e, g;
      logic [17:0] obs;
      rst       = rstn;
      op        = o;
      mem_ready = rdy;
      e.tag  = tag;
      e.st   = exp_st;
      e.ctrl = ref_ctrl(exp_st, o, rdy, rstn);
      e.ill  = exp_ill;
      sb.push_back(e);
      @(negedge clk);
      g   = sb.pop_front();
      obs = {mem_read, mem_write, adr_src, ir_write, pc_write, reg_write,
             alu_src_a, alu_src_b, alu_op, imm_src, result_src, branch};
      total++;
      assert (state === g.st) passes++;
      else $error("FAIL %s state: observed %0d expected %0d", g.tag, state, g.st);
      total++;
      assert (obs === g.ctrl) passes++;
      else $error("FAIL %s ctrl: observed %b expected %b", g.tag, obs, g.ctrl);
      total++;
      assert (illegal === g.ill) passes++;
      else $error("FAIL %s illegal: observed %b expected %b", g.tag, illegal, g.ill);
      @(posedge clk);
      #1;
   endtask

   localparam logic [6:0] R    = 7'b0110011;
   localparam logic [6:0] I    = 7'b0010011;
   localparam logic [6:0] LW   = 7'b0000011;
   localparam logic [6:0] SW   = 7'b0100011;
   localparam logic [6:0] BR   = 7'b1100011;
   localparam logic [6:0] JAL  = 7'b1101111;
   localparam logic [6:0] JALR = 7'b1100111;
   localparam logic [6:0] LUI  = 7'b0110111;
   localparam logic [6:0] BAD  = 7'b1111111;

   initial begin
      rst = 1'b0; op = R; mem_ready = 1'b1;
      #1;
      // Reset held low three cycles with memory ready.
      step("rst0", 0, R, 1, 4'd0, 0);
      step("rst1", 0, R, 1, 4'd0, 0);
      step("rst2", 0, R, 1, 4'd0, 0);
      // R-type: 0,1,6,8
      step("r_fetch", 1, R, 1, 4'd0, 0);
      step("r_dec",   1, R, 1, 4'd1, 0);
      step("r_exec",  1, R, 1, 4'd6, 0);
      step("r_wb",    1, R, 1, 4'd8, 0);
      // lw with two wait cycles in MEM_READ
      step("lw_fetch", 1, LW, 1, 4'd0, 0);
      step("lw_dec",   1, LW, 1, 4'd1, 0);
      step("lw_adr",   1, LW, 1, 4'd2, 0);
      step("lw_rd0",   1, LW, 0, 4'd3, 0);
      step("lw_rd1",   1, LW, 0, 4'd3, 0);
      step("lw_rd2",   1, LW, 1, 4'd3, 0);
      step("lw_wb",    1, LW, 1, 4'd4, 0);
      // branch with one fetch stall
      step("br_stall", 1, BR, 0, 4'd0, 0);
      step("br_fetch", 1, BR, 1, 4'd0, 0);
      step("br_dec",   1, BR, 1, 4'd1, 0);
      step("br_cmp",   1, BR, 1, 4'd9, 0);
      // I-type
      step("i_fetch", 1, I, 1, 4'd0, 0);
      step("i_dec",   1, I, 1, 4'd1, 0);
      step("i_exec",  1, I, 1, 4'd7, 0);
      step("i_wb",    1, I, 1, 4'd8, 0);
      // jal
      step("jal_fetch", 1, JAL, 1, 4'd0, 0);
      step("jal_dec",   1, JAL, 1, 4'd1, 0);
      step("jal_jmp",   1, JAL, 1, 4'd10, 0);
      step("jal_wb",    1, JAL, 1, 4'd8, 0);
      // lui
      step("lui_fetch", 1, LUI, 1, 4'd0, 0);
      step("lui_dec",   1, LUI, 1, 4'd1, 0);
      step("lui_wb",    1, LUI, 1, 4'd12, 0);
      // jalr: 0,1,11,10,8
      step("jalr_fetch", 1, JALR, 1, 4'd0, 0);
      step("jalr_dec",   1, JALR, 1, 4'd1, 0);
      step("jalr_adr",   1, JALR, 1, 4'd11, 0);
      step("jalr_jmp",   1, JALR, 1, 4'd10, 0);
      step("jalr_wb",    1, JALR, 1, 4'd8, 0);
      // illegal opcode, twice; flag is sticky
      step("bad_fetch",  1, BAD, 1, 4'd0, 0);
      step("bad_dec",    1, BAD, 1, 4'd1, 0);
      step("bad_fetch2", 1, BAD, 1, 4'd0, 1);
      step("bad_dec2",   1, BAD, 1, 4'd1, 1);
      step("post_fetch", 1, R, 1, 4'd0, 1);
      step("post_dec",   1, R, 1, 4'd1, 1);
      step("post_exec",  1, R, 1, 4'd6, 1);
      step("post_wb",    1, R, 1, 4'd8, 1);
      // sw interrupted by reset while waiting in MEM_WRITE
      step("sw_fetch", 1, SW, 1, 4'd0, 1);
      step("sw_dec",   1, SW, 1, 4'd1, 1);
      step("sw_adr",   1, SW, 1, 4'd2, 1);
      step("sw_wait",  1, SW, 0, 4'd5, 1);
      step("sw_rst",   0, SW, 0, 4'd0, 0);
      step("rel_stall", 1, R, 0, 4'd0, 0);
      step("rel_fetch", 1, R, 1, 4'd0, 0);
      step("rel_dec",   1, R, 1, 4'd1, 0);
      step("rel_exec",  1, R, 1, 4'd6, 0);
      step("rel_wb",    1, R, 1, 4'd8, 0);
      // sw completing normally: 4 cycles
      step("sw2_fetch", 1, SW, 1, 4'd0, 0);
      step("sw2_dec",   1, SW, 1, 4'd1, 0);
      step("sw2_adr",   1, SW, 1, 4'd2, 0);
      step("sw2_wr",    1, SW, 1, 4'd5, 0);
      step("sw2_next",  1, R, 0, 4'd0, 0);

      total++;
      assert (sb.size() == 0) passes++;
      else $error("FAIL scoreboard_drain: observed %0d expected 0", sb.size());

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire

// File: doc/multicycle_main_controller.md
Name: multicycle_main_controller

Overview:
- Main control FSM for the multi-cycle RISC-V datapath. Sequences each instruction through fetch, decode, execute, memory and writeback.
- Generates every datapath mux select and write enable.
- Produces the `branch` qualifier consumed by the downstream branch-condition unit. That unit combines `branch` with func3/zero/neg into the conditional PC-write term.
- Datapath PC enable is `pc_write | branch_taken`, formed outside this block.

Parameters:
STATE_W, 4, width of the `state` debug output. Fixed encoding: FETCH=0, DECODE=1, MEM_ADR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC_R=6, EXEC_I=7, ALU_WB=8, BRANCH=9, JAL=10, JALR_ADR=11, LUI=12.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
op  input  7  opcode field of the instruction register
mem_ready  input  1  memory handshake; the current access completes in the cycle this is high
mem_read  output  1  memory read request
mem_write  output  1  memory write request
adr_src  output  1  memory address select: 0 = PC, 1 = ALUOut
ir_write  output  1  load IR and OldPC
pc_write  output  1  unconditional PC write
reg_write  output  1  register file write
alu_src_a  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1
alu_src_b  output  2  ALU B select: 00 = rs2, 01 = immediate, 10 = constant 4
alu_op  output  2  00 = add, 01 = subtract, 10 = decode func3/func7
imm_src  output  3  immediate format: 000 = I, 001 = S, 010 = B, 011 = J, 100 = U
result_src  output  2  result bus select: 00 = ALUOut, 01 = memory data register, 10 = ALU result, 11 = immediate
branch  output  1  branch-compare qualifier to the branch-condition unit
illegal  output  1  sticky flag: an unsupported opcode was decoded
state  output  STATE_W  current state, for debug

Behaviour:
- State register only; outputs decode combinationally from state. `mem_ready` gates only `ir_write` and `pc_write` in FETCH.
- Unlisted outputs are 0 in every state; `imm_src` defaults to 000 where unlisted.

Reset:
- `rst` low forces state FETCH and `illegal` = 0 immediately, asynchronously.
- While `rst` is low, `mem_read`, `mem_write`, `pc_write`, `ir_write`, `reg_write` and `branch` are all 0.
- While `rst` is low, mux selects take FETCH values: `adr_src` = 0, `alu_src_a` = 00, `alu_src_b` = 10, `alu_op` = 00, `result_src` = 10.
- Reset in any state, including memory wait states, abandons the instruction. No write enable is asserted afterward for that instruction.

States and transitions:
- FETCH
  - Outputs: `mem_read` = 1, `adr_src` = 0, A = PC, B = 4, `alu_op` = add, `result_src` = 10.
  - `ir_write` = `pc_write` = `mem_ready`.
  - Stays in FETCH while `mem_ready` = 0; goes to DECODE when `mem_ready` = 1.
- DECODE
  - Outputs: A = OldPC, B = immediate, add. ALUOut receives the branch/JAL target.
  - `imm_src`: B for opcode 1100011, J for 1101111, otherwise I.
  - Next state by opcode:
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 0000011 or 0100011 → MEM_ADR
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR_ADR
    - 0110111 → LUI
    - any other opcode → FETCH, and `illegal` is set on that edge.
- MEM_ADR
  - Outputs: A = rs1, B = immediate, add; `imm_src` = S when `op[5]` = 1, otherwise I.
  - Next: MEM_WRITE when `op[5]` = 1, otherwise MEM_READ.
- MEM_READ
  - Outputs: `mem_read` = 1, `adr_src` = 1.
  - Holds until `mem_ready` = 1, then MEM_WB.
- MEM_WB
  - Outputs: `result_src` = 01, `reg_write` = 1.
  - Next: FETCH.
- MEM_WRITE
  - Outputs: `mem_write` = 1, `adr_src` = 1.
  - Holds until `mem_ready` = 1, then FETCH.
- EXEC_R
  - Outputs: A = rs1, B = rs2, `alu_op` = 10.
  - Next: ALU_WB.
- EXEC_I
  - Outputs: A = rs1, B = immediate, `imm_src` = I, `alu_op` = 10.
  - Next: ALU_WB.
- ALU_WB
  - Outputs: `result_src` = 00, `reg_write` = 1.
  - Next: FETCH.
- BRANCH
  - Outputs: A = rs1, B = rs2, `alu_op` = subtract, `branch` = 1, `result_src` = 00 (target onto the PC bus).
  - Next: FETCH.
- JAL
  - Outputs: A = OldPC, B = 4, add, `result_src` = 00, `pc_write` = 1.
  - PC receives the target; ALUOut receives the link address.
  - Next: ALU_WB.
- JALR_ADR
  - Outputs: A = rs1, B = immediate, `imm_src` = I, add.
  - Next: JAL (shared link-and-jump step).
- LUI
  - Outputs: `imm_src` = U, `result_src` = 11, `reg_write` = 1.
  - Next: FETCH.

Latency (with `mem_ready` high on first request):
- R-type and I-type: 4 cycles.
- lw: 5 cycles.
- sw: 4 cycles.
- branch: 3 cycles.
- jal: 4 cycles.
- jalr: 5 cycles.
- lui: 3 cycles.
- Each cycle `mem_ready` is low in FETCH, MEM_READ or MEM_WRITE adds one cycle, with all outputs held constant.

Flag and width rules:
- `illegal` clears only on reset; repeated illegal opcodes leave it at 1.
- `state` is zero-extended when STATE_W > 4.

Test Plan:
- `rst` held low 3 cycles with `mem_ready` = 1 → `state` = 0, `pc_write` = `ir_write` = `mem_read` = 0. Release → `mem_read` = 1, `pc_write` = 1.
- `op` = 0110011, `mem_ready` = 1 → states 0, 1, 6, 8, 0.
  - `reg_write` = 1 only in state 8.
  - `alu_op` = 10 in state 6.
- `op` = 0000011, `mem_ready` low for 2 cycles in MEM_READ → state 3 persists 3 cycles with `adr_src` = 1, then state 4 with `result_src` = 01 and `reg_write` = 1.
- `op` = 1100011 → in state 9: `branch` = 1, `alu_op` = 01, `alu_src_a` = 10, `alu_src_b` = 00, `pc_write` = 0.
- `op` = 1100111 → states 0, 1, 11, 10, 8; `pc_write` = 1 in state 10. Then `op` = 1111111 → DECODE returns to FETCH and `illegal` stays 1 until reset.
- Reset pulsed during MEM_WRITE with `mem_ready` = 0 → immediate `state` = 0 and `mem_write` = 0. No `reg_write` or `mem_write` follows.
